// File: rtl/mixer_fade_ctrl.sv
// Volume-fade sequencer: host-programmed targets, round-robin one-step sweeps pushed to the mixer.
// Optional build macro MIXFADE_IRQ_EN adds the irq output and CTRL.IRQ_EN (bit1).
module mixer_fade_ctrl #(
    parameter int N_CH  = 4,
    parameter int VOL_W = 4,
    parameter int PER_W = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    output logic        ready,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata
`ifdef MIXFADE_IRQ_EN
    ,
    output logic        irq
`endif
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

    typedef enum logic [1:0] {IDLE, SCAN, WRITE, NEXT} state_t;

    state_t           state_reg, state_next;
    logic [CH_W-1:0]  ch_reg, ch_next;
    logic             enable_reg;
    logic [PER_W-1:0] period_reg;
    logic [PER_W-1:0] presc_reg;
    logic             ovr_reg;
    logic [VOL_W-1:0] target_reg [N_CH];
    logic [VOL_W-1:0] cur_reg [N_CH];
    logic [N_CH-1:0]  diff;
    logic             ready_reg;
    logic [31:0]      rdata_reg;
    logic             m_valid_reg;
    logic [31:0]      m_addr_reg;
    logic [31:0]      m_wdata_reg;

    logic             accept;
    logic             wr_en;
    logic [3:0]       reg_idx;
    logic [31:0]      idx_ext;
    logic [31:0]      rd_val;
    logic             tick;
    logic             ovr_clr;
    logic             scan_write;
    logic             sweep_done;
    logic [VOL_W-1:0] cur_sel;
    logic [VOL_W-1:0] tgt_sel;
    logic [VOL_W-1:0] step_val;

    assign accept  = valid && !ready_reg;
    assign wr_en   = accept && wstrb[0];
    assign reg_idx = addr[5:2];
    assign idx_ext = {28'd0, reg_idx};
    assign tick    = enable_reg && (presc_reg == period_reg);
    assign ovr_clr = wr_en && (reg_idx == 4'd2) && wdata[1];

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_diff
            assign diff[gi] = (cur_reg[gi] != target_reg[gi]);
        end
    endgenerate

    assign cur_sel  = cur_reg[ch_reg];
    assign tgt_sel  = target_reg[ch_reg];
    assign step_val = (cur_sel < tgt_sel) ? cur_sel + 1'b1 : cur_sel - 1'b1;

`ifdef MIXFADE_IRQ_EN
    logic irq_en_reg;
    logic irq_reg;
    logic wrote_reg;
    assign irq = irq_reg;

    // irq only for sweeps that actually moved something and left every channel settled
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq_en_reg <= 1'b0;
            irq_reg    <= 1'b0;
            wrote_reg  <= 1'b0;
        end else begin
            if (wr_en && reg_idx == 4'd0) irq_en_reg <= wdata[1];
            irq_reg <= sweep_done && irq_en_reg && wrote_reg && (diff == '0);
            if (state_reg == IDLE && tick) wrote_reg <= 1'b0;
            else if (scan_write)           wrote_reg <= 1'b1;
        end
    end
`endif

    always_comb begin
        rd_val = 32'd0;
        case (reg_idx)
            4'd0: begin
                rd_val[0] = enable_reg;
`ifdef MIXFADE_IRQ_EN
                rd_val[1] = irq_en_reg;
`endif
            end
            4'd1: rd_val[PER_W-1:0] = period_reg;
            4'd2: begin
                rd_val[0]        = (state_reg != IDLE);
                rd_val[1]        = ovr_reg;
                rd_val[8 +: N_CH] = diff;
            end
            default: ;
        endcase
        for (int i = 0; i < N_CH; i++) begin
            if (idx_ext == 32'(4 + i))  rd_val = {{(32-VOL_W){1'b0}}, target_reg[i]};
            if (idx_ext == 32'(12 + i)) rd_val = {{(32-VOL_W){1'b0}}, cur_reg[i]};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_reg  <= 1'b0;
            rdata_reg  <= 32'd0;
            enable_reg <= 1'b0;
            period_reg <= '0;
            ovr_reg    <= 1'b0;
            presc_reg  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                target_reg[i] <= '0;
                cur_reg[i]    <= '0;
            end
        end else begin
            ready_reg <= accept;
            rdata_reg <= accept ? rd_val : 32'd0;
            if (wr_en && reg_idx == 4'd0) enable_reg <= wdata[0];
            if (wr_en && reg_idx == 4'd1) period_reg <= wdata[PER_W-1:0];
            // a tick landing on the clear cycle wins, so no overrun is ever lost
            ovr_reg   <= (ovr_reg && !ovr_clr) || (tick && state_reg != IDLE);
            presc_reg <= (!enable_reg || tick) ? '0 : presc_reg + 1'b1;
            for (int i = 0; i < N_CH; i++) begin
                if (wr_en && idx_ext == 32'(4 + i)) target_reg[i] <= wdata[VOL_W-1:0];
                if (scan_write && ch_reg == CH_W'(i)) cur_reg[i] <= step_val;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
            ch_reg    <= '0;
        end else begin
            state_reg <= state_next;
            ch_reg    <= ch_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ch_next    = ch_reg;
        scan_write = 1'b0;
        sweep_done = 1'b0;
        case (state_reg)
            IDLE: if (tick) begin
                state_next = SCAN;
                ch_next    = '0;
            end
            SCAN: if (diff[ch_reg]) begin
                scan_write = 1'b1;
                state_next = WRITE;
            end else begin
                state_next = NEXT;
            end
            WRITE: if (m_ready) state_next = NEXT;
            NEXT: if (ch_reg == LAST_CH) begin
                state_next = IDLE;
                sweep_done = 1'b1;
            end else begin
                ch_next    = ch_reg + 1'b1;
                state_next = SCAN;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid_reg <= 1'b0;
            m_addr_reg  <= 32'd0;
            m_wdata_reg <= 32'd0;
        end else if (scan_write) begin
            m_valid_reg <= 1'b1;
            m_addr_reg  <= {{(30-CH_W){1'b0}}, ch_reg, 2'b00};
            m_wdata_reg <= {{(32-VOL_W){1'b0}}, step_val};
        end else if (state_reg == WRITE && m_ready) begin
            m_valid_reg <= 1'b0;
        end
    end

    assign ready   = ready_reg;
    assign rdata   = rdata_reg;
    assign m_valid = m_valid_reg;
    assign m_addr  = m_addr_reg;
    assign m_wdata = m_wdata_reg;
    assign m_wstrb = m_valid_reg ? 4'b0001 : 4'b0000;

endmodule

// File: tb/tb_mixer_fade_ctrl.sv
// Bench for mixer_fade_ctrl: register table, sweep-sequence model, mixer responder, reset/irq corners.
module tb_mixer_fade_ctrl;
    localparam int N_CH  = 4;
    localparam int VOL_W = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid;
    logic        ready;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        m_valid;
    logic        m_ready;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
`ifdef MIXFADE_IRQ_EN
    logic        irq;
`endif

    mixer_fade_ctrl #(.N_CH(N_CH), .VOL_W(VOL_W), .PER_W(16)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .valid   (valid),
        .ready   (ready),
        .wstrb   (wstrb),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_wstrb (m_wstrb),
        .m_addr  (m_addr),
        .m_wdata (m_wdata)
`ifdef MIXFADE_IRQ_EN
        , .irq   (irq)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    int  n_tot = 0;
    int  n_pass = 0;
    int  cyc = 0;
    wr_t wq[$];
    int  lat_cfg = 0;
    int  stab_err = 0;
    int  ack_err = 0;
    int  strb_err = 0;
    int  irq_hi = 0;
    int  irq_cyc = 0;
    logic [VOL_W-1:0] mcur[N_CH];
    logic [VOL_W-1:0] mtgt[N_CH];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
    endtask

    // Mixer side: records each write once, acks after lat_cfg samples (random 0..3 when negative).
    initial begin
        bit          pending;
        int          cnt;
        logic [31:0] pa, pd;
        pending = 0;
        cnt     = 0;
        pa      = 0;
        pd      = 0;
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!resetn) begin
                m_ready = 1'b0;
                pending = 0;
            end else if (m_ready) begin
                m_ready = 1'b0;
                pending = 0;
                if (m_valid) ack_err++;
            end else if (m_valid) begin
                if (!pending) begin
                    wq.push_back('{m_addr, m_wdata, cyc});
                    $display("mixer write addr=0x%02h wdata=%0d cyc=%0d", m_addr, m_wdata, cyc);
                    pa      = m_addr;
                    pd      = m_wdata;
                    pending = 1;
                    cnt     = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
                end else if (m_addr !== pa || m_wdata !== pd) begin
                    stab_err++;
                end
                if (m_wstrb !== 4'b0001) strb_err++;
                if (cnt == 0) m_ready = 1'b1;
                else cnt--;
            end else if (m_wstrb !== 4'b0000) begin
                strb_err++;
            end
`ifdef MIXFADE_IRQ_EN
            if (irq === 1'b1) begin
                irq_hi++;
                irq_cyc = cyc;
            end
`endif
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       output logic [31:0] r);
        @(posedge clk);
        #1;
        addr  = a;
        wstrb = s;
        wdata = d;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        wstrb = 4'd0;
        chk("ready_pulse", {31'd0, ready}, 32'd1);
        r = rdata;
        $display("host %s addr=0x%02h wdata=0x%08h rdata=0x%08h", (s[0] ? "wr" : "rd"), a, d, r);
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        bus(a, 4'b0001, d, r);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] r);
        bus(a, 4'b0000, 32'd0, r);
    endtask

    task automatic wait_idle(input string nm);
        logic [31:0] s;
        int k;
        k = 0;
        do begin
            rd(32'h08, s);
            k++;
        end while (s[0] && k < 100);
        chk({nm, "_idle"}, {31'd0, s[0]}, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #3 resetn = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            mcur[i] = '0;
            mtgt[i] = '0;
        end
    endtask

    // Expected writes: whole sweeps, each channel that differs moves one step, in channel order.
    task automatic sweep_run(input string nm, input int per, input int lat);
        wr_t exp[$];
        logic [VOL_W-1:0] c[N_CH];
        logic [31:0] r;
        bit moved;
        int k;
        for (int i = 0; i < N_CH; i++) c[i] = mcur[i];
        moved = 1;
        while (moved) begin
            moved = 0;
            for (int i = 0; i < N_CH; i++) begin
                if (c[i] != mtgt[i]) begin
                    moved = 1;
                    c[i] = (c[i] < mtgt[i]) ? c[i] + 1'b1 : c[i] - 1'b1;
                    exp.push_back('{32'(i * 4), 32'(c[i]), 0});
                end
            end
        end
        lat_cfg = lat;
        wq.delete();
        wr(32'h04, 32'(per));
        for (int i = 0; i < N_CH; i++) wr(32'h10 + 32'(4 * i), 32'(mtgt[i]));
        wr(32'h00, 32'd1);
        k = 0;
        while (wq.size() < exp.size() && k < 4000) begin
            @(posedge clk);
            k++;
        end
        chk({nm, "_progress"}, {31'd0, k < 4000}, 32'd1);
        repeat ((per + 1) * 3 + 40) @(posedge clk);
        wr(32'h00, 32'd0);
        wait_idle(nm);
        chk({nm, "_count"}, wq.size(), exp.size());
        for (int i = 0; i < exp.size() && i < wq.size(); i++) begin
            chk($sformatf("%s_addr%0d", nm, i), wq[i].a, exp[i].a);
            chk($sformatf("%s_data%0d", nm, i), wq[i].d, exp[i].d);
        end
        for (int i = 0; i < N_CH; i++) begin
            mcur[i] = mtgt[i];
            rd(32'h30 + 32'(4 * i), r);
            chk($sformatf("%s_cur%0d", nm, i), r, 32'(mtgt[i]));
        end
    endtask

    initial begin
        vec_t vt[24];
        logic [31:0] r;
        logic [31:0] ctrl_b1;
        int k;
        int n0;
`ifdef MIXFADE_IRQ_EN
        ctrl_b1 = 32'h2;
`else
        ctrl_b1 = 32'h0;
`endif
        vt[0]  = '{32'h00, 4'h0, 32'h0,        32'h0};
        vt[1]  = '{32'h04, 4'h0, 32'h0,        32'h0};
        vt[2]  = '{32'h08, 4'h0, 32'h0,        32'h0};
        vt[3]  = '{32'h10, 4'h0, 32'h0,        32'h0};
        vt[4]  = '{32'h1C, 4'h0, 32'h0,        32'h0};
        vt[5]  = '{32'h30, 4'h0, 32'h0,        32'h0};
        vt[6]  = '{32'h3C, 4'h0, 32'h0,        32'h0};
        vt[7]  = '{32'h04, 4'h1, 32'hFFFFABCD, 32'h0};
        vt[8]  = '{32'h04, 4'h0, 32'h0,        32'h0000ABCD};
        vt[9]  = '{32'h04, 4'hE, 32'h5,        32'h0};
        vt[10] = '{32'h04, 4'h0, 32'h0,        32'h0000ABCD};
        vt[11] = '{32'h14, 4'h1, 32'hFF,       32'h0};
        vt[12] = '{32'h14, 4'h0, 32'h0,        32'hF};
        vt[13] = '{32'h08, 4'h0, 32'h0,        32'h200};
        vt[14] = '{32'h34, 4'h1, 32'h7,        32'h0};
        vt[15] = '{32'h34, 4'h0, 32'h0,        32'h0};
        vt[16] = '{32'h20, 4'h1, 32'h55,       32'h0};
        vt[17] = '{32'h20, 4'h0, 32'h0,        32'h0};
        vt[18] = '{32'h00, 4'h1, 32'hFFFFFFFC, 32'h0};
        vt[19] = '{32'h00, 4'h0, 32'h0,        32'h0};
        vt[20] = '{32'h00, 4'h1, 32'h2,        32'h0};
        vt[21] = '{32'h00, 4'h0, 32'h0,        ctrl_b1};
        vt[22] = '{32'h14, 4'h1, 32'h0,        32'h0};
        vt[23] = '{32'h04, 4'h1, 32'h0,        32'h0};

        resetn = 1'b0;
        valid  = 1'b0;
        wstrb  = 4'd0;
        addr   = 32'd0;
        wdata  = 32'd0;
        for (int i = 0; i < N_CH; i++) begin
            mcur[i] = '0;
            mtgt[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        #2 resetn = 1'b1;

        // Register map table
        for (int i = 0; i < 24; i++) begin
            bus(vt[i].addr, vt[i].wstrb, vt[i].wdata, r);
            if (vt[i].wstrb == 4'h0) chk($sformatf("vec%0d", i), r, vt[i].exp);
        end
        wr(32'h00, 32'd0);

        // Disabled: no mixer traffic
        wq.delete();
        repeat (100) @(posedge clk);
        chk("t1_no_writes", wq.size(), 0);

        // Single-channel ramp with tick spacing of PERIOD+1
        mtgt[2] = 4'd3;
        sweep_run("t2", 9, 0);
        if (wq.size() >= 3) begin
            chk("t2_spacing01", wq[1].cyc - wq[0].cyc, 10);
            chk("t2_spacing12", wq[2].cyc - wq[1].cyc, 10);
        end
        rd(32'h08, r);
        chk("t2_status_ch2", r & 32'h400, 32'd0);

        // Ramp up then down
        mtgt[0] = 4'd5;
        sweep_run("t3up", 4, 0);
        mtgt[0] = 4'd2;
        sweep_run("t3dn", 4, 0);

        // Random targets, periods and mixer latencies
        for (int rr = 0; rr < 8; rr++) begin
            for (int i = 0; i < N_CH; i++) mtgt[i] = VOL_W'($urandom_range(0, 15));
            sweep_run($sformatf("rnd%0d", rr), int'($urandom_range(0, 15)), -1);
        end

        // Slow mixer, all channels, then overrun flag
        do_reset();
        stab_err = 0;
        for (int i = 0; i < N_CH; i++) mtgt[i] = 4'd1;
        sweep_run("t4", 60, 5);
        chk("t4_stable", stab_err, 0);
        wr(32'h04, 32'd0);
        wr(32'h00, 32'd1);
        repeat (20) @(posedge clk);
        wr(32'h00, 32'd0);
        wait_idle("t4ovr");
        rd(32'h08, r);
        chk("t4_ovr_set", r & 32'h2, 32'h2);
        wr(32'h08, 32'h0);
        rd(32'h08, r);
        chk("t4_ovr_kept", r & 32'h2, 32'h2);
        wr(32'h08, 32'h2);
        rd(32'h08, r);
        chk("t4_ovr_clr", r & 32'h2, 32'h0);

        // Asynchronous reset in the middle of a mixer write
        lat_cfg = 30;
        wr(32'h1C, 32'd9);
        wr(32'h00, 32'd1);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!m_valid && k < 200);
        chk("t5_mvalid_seen", {31'd0, m_valid}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("t5_mvalid_async", {31'd0, m_valid}, 32'd0);
        chk("t5_mwstrb_async", {28'd0, m_wstrb}, 32'd0);
        repeat (2) @(posedge clk);
        #3 resetn = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            mcur[i] = '0;
            mtgt[i] = '0;
        end
        n0 = wq.size();
        repeat (60) @(posedge clk);
        chk("t5_no_resume", wq.size(), n0);
        rd(32'h3C, r);
        chk("t5_cur3", r, 32'd0);
        rd(32'h00, r);
        chk("t5_ctrl", r, 32'd0);

`ifdef MIXFADE_IRQ_EN
        // Sweep-done interrupt
        do_reset();
        lat_cfg = 0;
        irq_hi  = 0;
        wq.delete();
        wr(32'h04, 32'd20);
        wr(32'h14, 32'd2);
        wr(32'h00, 32'd3);
        repeat (200) @(posedge clk);
        chk("t6_irq_once", irq_hi, 1);
        if (wq.size() >= 2) chk("t6_irq_after_2nd", {31'd0, irq_cyc > wq[1].cyc}, 32'd1);
        wr(32'h00, 32'd0);
        wait_idle("t6");
`endif

        chk("ack_drop", ack_err, 0);
        chk("m_wstrb_value", strb_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
